jtag_ir_dr_ctrl: RTL and testbench
==================================

// Module: jtag_ir_dr_ctrl
// PURPOSE
// - Instruction/data-register sequencer behind the TAP state machine. It consumes the TAP's
//   capture/shift/update strobes and owns the IR shift and hold registers and opcode decode.
// - Owns the BYPASS, IDCODE and USER data registers and the TDO output mux.
// - Publishes the decoded instruction and a USER update port toward the debug fabric.
// PARAMETERS
// - IR_W       5              instruction register width (>=2)
// - IDCODE_VAL 32'h1000_0A4D  IDCODE value; bit0 must be 1
// - USER_W     32             USER data register width
// - OP_IDCODE  5'b00001       IDCODE opcode
// - OP_USER    5'b10000       USER opcode
// - OP_BYPASS  all-ones       BYPASS opcode; any unlisted opcode decodes as BYPASS
// PORTS
// - tck                 in   1       JTAG test clock
// - trst                in   1       async active-low reset
// - tdi                 in   1       serial data in
// - reset               in   1       TAP in Test-Logic-Reset (registered on negedge tck)
// - select              in   1       1 = IR path, 0 = DR path
// - tdo_en              in   1       TAP shift-state indicator, passed through
// - captureIR/shiftIR   in   1       TAP IR capture/shift strobes (stable across posedge)
// - captureDR/shiftDR   in   1       TAP DR capture/shift strobes (stable across posedge)
// - update_ir_st        in   1       TAP in Update-IR (level)
// - update_dr_st        in   1       TAP in Update-DR (level)
// - user_capture_data   in   USER_W  parallel value loaded on Capture-DR under USER
// - tdo                 out  1       serial data out, changes on negedge tck
// - tdo_oe              out  1       tdo output enable
// - instr               out  IR_W    current hold-register instruction
// - user_update_data    out  USER_W  USER DR value latched on Update-DR
// - user_update_pulse   out  1       high for one tck period after a USER update
// BEHAVIOUR
// - Reset: trst low asynchronously forces the following; all other flops are don't-care.
//   - instr = OP_IDCODE
//   - tdo = 0, tdo_oe = 0
//   - user_update_data = 0, user_update_pulse = 0
// - Posedge tck, IR path:
//   - captureIR loads ir_sr = {(IR_W-2){0}, 2'b01}.
//   - shiftIR shifts ir_sr = {tdi, ir_sr[IR_W-1:1]}, LSB first.
// - Posedge tck, DR path: the register selected by decode of instr is operated on.
//   - BYPASS: 1 bit; captureDR loads 0; shiftDR loads tdi.
//   - IDCODE: 32 bits; captureDR loads IDCODE_VAL; shiftDR shifts in tdi at MSB.
//   - USER: captureDR loads user_capture_data; shiftDR shifts as above.
// - Non-selected DRs hold their value. Capture and shift are never both asserted; if they are,
//   capture wins.
// - Negedge tck, ordered by priority:
//   - reset=1: instr <= OP_IDCODE.
//   - else update_ir_st: instr <= ir_sr.
//   - else update_dr_st && instr==OP_USER: user_update_data <= user_sr and user_update_pulse <= 1.
//   - user_update_pulse self-clears on the next negedge, so it is exactly one tck period wide.
// - Negedge tck, TDO:
//   - tdo <= select ? ir_sr[0] : selected_dr[0].
//   - tdo_oe <= tdo_en. Both lag the shift state by a half cycle, per 1149.1.
// - instr changes only in Update-IR or Test-Logic-Reset, never mid-shift.
// - A shift of any length is legal: a short shift leaves partially shifted contents, and an
//   overlong shift passes bits through.
// - trst asserted mid-shift aborts the shift. The shift registers need no reset, since the next
//   capture reinitialises them.
// STRUCTURE
// - Shared package jtag_pkg holds the following:
//   - IR_W and the opcode localparams OP_BYPASS, OP_IDCODE, OP_USER.
//   - typedef enum jtag_dr_sel_e {DR_BYPASS, DR_IDCODE, DR_USER}.
//   - function decode_ir(), which maps an opcode to jtag_dr_sel_e.
// - One sub-module, jtag_shift_reg #(W): a capture/shift register with cap_en, shift_en,
//   cap_val, tdi, q and so.
//   - It is instantiated for IR, IDCODE and USER.
//   - BYPASS stays a single inline flop.
// TESTING
// - trst pulse, then 32 DR shifts with tdi=0 -> instr==OP_IDCODE; tdo stream LSB-first equals
//   32'h1000_0A4D; tdo_oe high only during the shift.
// - Shift IR with 5'b11111 then Update-IR -> instr==5'b11111. A DR shift of 8'hA5 then returns
//   8'hA5 delayed by exactly 1 bit, first bit 0.
// - IR capture then 5 shifts -> tdo yields 1,0,0,0,0.
// - Load OP_USER, set user_capture_data=32'hDEAD_BEEF, shift 32 bits of 32'h1234_5678 ->
//   tdo stream = DEAD_BEEF; after Update-DR, user_update_data==32'h1234_5678 and
//   user_update_pulse is high for one tck.
// - Load unlisted opcode 5'b00110 -> DR path behaves as BYPASS, and a 1-bit delay is observed.
// - Load OP_USER, then hold TMS high for 5 tck (reset=1) -> instr returns to OP_IDCODE;
//   assert trst mid-DR-shift -> outputs return to reset values immediately.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG IR/DR sequencer.
// - IR_W and the default opcodes (BYPASS, IDCODE, USER)
// - jtag_dr_sel_e: which data register the current instruction selects
// - decode_ir(): maps an opcode to a data-register select
package jtag_pkg;

  localparam int unsigned IR_W = 5;

  localparam logic [IR_W-1:0] OP_BYPASS = '1;
  localparam logic [IR_W-1:0] OP_IDCODE = 5'b00001;
  localparam logic [IR_W-1:0] OP_USER   = 5'b10000;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } jtag_dr_sel_e;

  // Opcodes arrive zero-extended to 32 bits so the function serves any IR width up to 32.
  // Anything not explicitly listed falls back to BYPASS, as 1149.1 requires.
  function automatic jtag_dr_sel_e decode_ir(input logic [31:0] op,
                                             input logic [31:0] op_idcode,
                                             input logic [31:0] op_user,
                                             input logic [31:0] op_bypass);
    jtag_dr_sel_e sel;
    if (op == op_bypass) begin
      sel = DR_BYPASS;
    end else if (op == op_idcode) begin
      sel = DR_IDCODE;
    end else if (op == op_user) begin
      sel = DR_USER;
    end else begin
      sel = DR_BYPASS;
    end
    return sel;
  endfunction

endpackage

// File: rtl/jtag_ir_dr_ctrl_if.sv
// TAP-side connection of the IR/DR sequencer.
// - master: the TAP state machine; drives the state strobes and tdi, receives tdo/tdo_oe
// - slave:  the sequencer; consumes the strobes, drives tdo/tdo_oe
// Signals:
//   tdi                  serial data in
//   reset                TAP in Test-Logic-Reset
//   select               1 = IR path, 0 = DR path
//   tdo_en               TAP in a shift state
//   captureIR/shiftIR    IR capture/shift strobes
//   captureDR/shiftDR    DR capture/shift strobes
//   update_ir_st         TAP in Update-IR
//   update_dr_st         TAP in Update-DR
//   tdo, tdo_oe          serial data out and its enable
interface jtag_ir_dr_ctrl_if;

  logic tdi;
  logic reset;
  logic select;
  logic tdo_en;
  logic captureIR;
  logic shiftIR;
  logic captureDR;
  logic shiftDR;
  logic update_ir_st;
  logic update_dr_st;
  logic tdo;
  logic tdo_oe;

  modport master (
    output tdi, reset, select, tdo_en,
    output captureIR, shiftIR, captureDR, shiftDR,
    output update_ir_st, update_dr_st,
    input  tdo, tdo_oe
  );

  modport slave (
    input  tdi, reset, select, tdo_en,
    input  captureIR, shiftIR, captureDR, shiftDR,
    input  update_ir_st, update_dr_st,
    output tdo, tdo_oe
  );

endinterface

// File: rtl/jtag_shift_reg.sv
// Capture/shift register clocked on posedge tck, LSB shifted out first.
// Ports:
//   tck       JTAG test clock
//   cap_en    load cap_val (wins over shift_en)
//   shift_en  shift right, tdi enters at the MSB
//   cap_val   parallel capture value
//   tdi       serial input
//   q         register contents
//   so        serial output (q[0])
// No reset: every use starts with a capture, which fully reinitialises the contents.
module jtag_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         tck,
  input  logic         cap_en,
  input  logic         shift_en,
  input  logic [W-1:0] cap_val,
  input  logic         tdi,
  output logic [W-1:0] q,
  output logic         so
);

  logic [W-1:0] q_d;

  always_comb begin
    q_d = q;
    if (cap_en) begin
      q_d = cap_val;
    end else if (shift_en) begin
      q_d = {tdi, q[W-1:1]};
    end
  end

  always_ff @(posedge tck) begin
    q <= q_d;
  end

  assign so = q[0];

endmodule

// File: rtl/jtag_ir_dr_ctrl.sv
// Instruction/data-register sequencer sitting behind the TAP state machine.
// Owns the IR shift/hold registers, opcode decode, the BYPASS/IDCODE/USER data registers
// and the TDO mux, and publishes the current instruction and a USER update port.
// Ports:
//   tck                 JTAG test clock
//   trst                asynchronous active-low reset
//   tap                 TAP strobes in, tdo/tdo_oe out (slave side)
//   user_capture_data   value loaded into USER on Capture-DR
//   instr               current instruction (hold register)
//   user_update_data    USER value latched on Update-DR
//   user_update_pulse   one tck period wide strobe following a USER update
// Shift/capture happen on posedge tck; updates and tdo on negedge tck.
module jtag_ir_dr_ctrl #(
  parameter int unsigned         IR_W       = jtag_pkg::IR_W,
  parameter logic [31:0]         IDCODE_VAL = 32'h1000_0A4D,
  parameter int unsigned         USER_W     = 32,
  parameter logic [IR_W-1:0]     OP_IDCODE  = jtag_pkg::OP_IDCODE,
  parameter logic [IR_W-1:0]     OP_USER    = jtag_pkg::OP_USER,
  parameter logic [IR_W-1:0]     OP_BYPASS  = '1
) (
  input  logic                tck,
  input  logic                trst,
  jtag_ir_dr_ctrl_if.slave    tap,
  input  logic [USER_W-1:0]   user_capture_data,
  output logic [IR_W-1:0]     instr,
  output logic [USER_W-1:0]   user_update_data,
  output logic                user_update_pulse
);

  import jtag_pkg::*;

  // Capture pattern mandated for the IR: ...0001, so a chain walk sees a 1 then 0s.
  localparam logic [IR_W-1:0] IrCapture = {{(IR_W-2){1'b0}}, 2'b01};

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [IR_W-1:0] instr_q, instr_d;
  jtag_dr_sel_e    dr_sel;

  always_comb begin
    dr_sel = decode_ir(32'(instr_q), 32'(OP_IDCODE), 32'(OP_USER), 32'(OP_BYPASS));
  end

  logic cap_idcode, shift_idcode;
  logic cap_user, shift_user;
  logic cap_bypass, shift_bypass;

  always_comb begin
    cap_idcode   = tap.captureDR && (dr_sel == DR_IDCODE);
    shift_idcode = tap.shiftDR   && (dr_sel == DR_IDCODE);
    cap_user     = tap.captureDR && (dr_sel == DR_USER);
    shift_user   = tap.shiftDR   && (dr_sel == DR_USER);
    cap_bypass   = tap.captureDR && (dr_sel == DR_BYPASS);
    shift_bypass = tap.shiftDR   && (dr_sel == DR_BYPASS);
  end

  // ---------------------------------------------------------------------------
  // Shift registers (posedge tck)
  // ---------------------------------------------------------------------------
  logic [IR_W-1:0]   ir_sr;
  logic              ir_so;
  logic [31:0]       idcode_q;
  logic              idcode_so;
  logic [USER_W-1:0] user_sr;
  logic              user_so;

  jtag_shift_reg #(
    .W (IR_W)
  ) u_ir_sr (
    .tck      (tck),
    .cap_en   (tap.captureIR),
    .shift_en (tap.shiftIR),
    .cap_val  (IrCapture),
    .tdi      (tap.tdi),
    .q        (ir_sr),
    .so       (ir_so)
  );

  jtag_shift_reg #(
    .W (32)
  ) u_idcode_sr (
    .tck      (tck),
    .cap_en   (cap_idcode),
    .shift_en (shift_idcode),
    .cap_val  (IDCODE_VAL),
    .tdi      (tap.tdi),
    .q        (idcode_q),
    .so       (idcode_so)
  );

  jtag_shift_reg #(
    .W (USER_W)
  ) u_user_sr (
    .tck      (tck),
    .cap_en   (cap_user),
    .shift_en (shift_user),
    .cap_val  (user_capture_data),
    .tdi      (tap.tdi),
    .q        (user_sr),
    .so       (user_so)
  );

  // Only the serial output of IDCODE ever leaves the block.
  logic unused_idcode;
  assign unused_idcode = ^idcode_q;

  // BYPASS is a single flop: captures 0, shifts tdi straight through.
  logic bypass_q, bypass_d;

  always_comb begin
    bypass_d = bypass_q;
    if (cap_bypass) begin
      bypass_d = 1'b0;
    end else if (shift_bypass) begin
      bypass_d = tap.tdi;
    end
  end

  always_ff @(posedge tck) begin
    bypass_q <= bypass_d;
  end

  // ---------------------------------------------------------------------------
  // Update / TDO (negedge tck)
  // ---------------------------------------------------------------------------
  logic              dr_so;
  logic [USER_W-1:0] upd_data_q, upd_data_d;
  logic              upd_pulse_q, upd_pulse_d;
  logic              tdo_q, tdo_d;
  logic              tdo_oe_q, tdo_oe_d;

  always_comb begin
    case (dr_sel)
      DR_IDCODE: dr_so = idcode_so;
      DR_USER:   dr_so = user_so;
      default:   dr_so = bypass_q;
    endcase
  end

  always_comb begin
    instr_d     = instr_q;
    upd_data_d  = upd_data_q;
    upd_pulse_d = 1'b0;  // self-clears unless re-armed this edge
    if (tap.reset) begin
      instr_d = OP_IDCODE;
    end else if (tap.update_ir_st) begin
      instr_d = ir_sr;
    end else if (tap.update_dr_st && (instr_q == OP_USER)) begin
      upd_data_d  = user_sr;
      upd_pulse_d = 1'b1;
    end
    // tdo lags the shift by half a cycle so the far end samples a stable bit on posedge.
    tdo_d    = tap.select ? ir_so : dr_so;
    tdo_oe_d = tap.tdo_en;
  end

  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      instr_q     <= OP_IDCODE;
      upd_data_q  <= '0;
      upd_pulse_q <= 1'b0;
      tdo_q       <= 1'b0;
      tdo_oe_q    <= 1'b0;
    end else begin
      instr_q     <= instr_d;
      upd_data_q  <= upd_data_d;
      upd_pulse_q <= upd_pulse_d;
      tdo_q       <= tdo_d;
      tdo_oe_q    <= tdo_oe_d;
    end
  end

  assign instr             = instr_q;
  assign user_update_data  = upd_data_q;
  assign user_update_pulse = upd_pulse_q;
  assign tap.tdo           = tdo_q;
  assign tap.tdo_oe        = tdo_oe_q;

endmodule

// File: tb/tb_jtag_ir_dr_ctrl.sv
// Self-checking bench for jtag_ir_dr_ctrl. The bench plays the TAP: each cycle it presents
// the strobes of one TAP state just after posedge, samples outputs 1 ns after negedge.
module tb_jtag_ir_dr_ctrl;

  localparam logic [31:0] IDCODE = 32'h1000_0A4D;
  localparam logic [4:0]  OpIdcode = 5'b00001;
  localparam logic [4:0]  OpUser   = 5'b10000;
  localparam logic [4:0]  OpBypass = 5'b11111;

  logic        tck;
  logic        trst;
  logic [31:0] user_capture_data;
  logic [4:0]  instr;
  logic [31:0] user_update_data;
  logic        user_update_pulse;

  jtag_ir_dr_ctrl_if tap ();

  jtag_ir_dr_ctrl #(
    .IR_W       (5),
    .IDCODE_VAL (IDCODE),
    .USER_W     (32),
    .OP_IDCODE  (OpIdcode),
    .OP_USER    (OpUser),
    .OP_BYPASS  (OpBypass)
  ) dut (
    .tck               (tck),
    .trst              (trst),
    .tap               (tap),
    .user_capture_data (user_capture_data),
    .instr             (instr),
    .user_update_data  (user_update_data),
    .user_update_pulse (user_update_pulse)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string       name;
    logic [63:0] val;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] cap_data;
    int          n;
    logic [63:0] din;
    int          exp_len;
    logic [63:0] exp_cap;
    bit          is_user;
  } vec_t;
  vec_t vecs[7];

  logic s_tdo, s_oe, s_pulse;
  logic pulse_upd, pulse_next;
  int   oe_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic set_tap(input logic sel, input logic capir, input logic shir,
                         input logic capdr, input logic shdr, input logic updir,
                         input logic upddr, input logic rst, input logic en, input logic d);
    tap.select       = sel;
    tap.captureIR    = capir;
    tap.shiftIR      = shir;
    tap.captureDR    = capdr;
    tap.shiftDR      = shdr;
    tap.update_ir_st = updir;
    tap.update_dr_st = upddr;
    tap.reset        = rst;
    tap.tdo_en       = en;
    tap.tdi          = d;
  endtask

  task automatic cycle();
    @(negedge tck);
    #1;
    s_tdo   = tap.tdo;
    s_oe    = tap.tdo_oe;
    s_pulse = user_update_pulse;
    if (s_oe !== tap.tdo_en) oe_err++;
    @(posedge tck);
    #1;
  endtask

  task automatic pop_check(input logic [63:0] got);
    sb_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.name, got, e.val);
    end
  endtask

  // Capture-IR, IR_W shifts of op, Exit1-IR, Update-IR.
  task automatic load_ir(input logic [4:0] op);
    logic [63:0] got;
    sb_t e;
    e.name = "ir_capture_stream";
    e.val  = 64'h1;  // tdo yields 1,0,0,0,0
    sb_q.push_back(e);
    got = '0;
    set_tap(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    for (int i = 0; i < 5; i++) begin
      set_tap(1, 0, 1, 0, 0, 0, 0, 0, 1, op[i]); cycle();
      got[i] = s_tdo;
    end
    set_tap(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    set_tap(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); cycle();
    set_tap(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pop_check(got);
  endtask

  // Capture-DR, n shifts, Exit1-DR, Update-DR, one idle cycle.
  task automatic shift_dr(input string name, input int n, input logic [63:0] din,
                          input logic [63:0] exp_stream);
    logic [63:0] got;
    sb_t e;
    e.name = name;
    e.val  = exp_stream;
    sb_q.push_back(e);
    got = '0;
    set_tap(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); cycle();
    for (int i = 0; i < n; i++) begin
      set_tap(0, 0, 0, 0, 1, 0, 0, 0, 1, din[i]); cycle();
      got[i] = s_tdo;
    end
    set_tap(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    set_tap(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); cycle();
    pulse_upd = s_pulse;
    set_tap(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    pulse_next = s_pulse;
    pop_check(got);
  endtask

  // Serial reference: a len-bit register preloaded with cap, shifted n times from din.
  function automatic logic [63:0] model_shift(input int len, input logic [63:0] cap,
                                              input logic [63:0] din, input int n,
                                              output logic [63:0] sr_out);
    logic [63:0] sr;
    logic [63:0] out;
    sr  = cap;
    out = '0;
    for (int k = 0; k < n; k++) begin
      out[k] = sr[0];
      sr = sr >> 1;
      sr[len-1] = din[k];
    end
    sr_out = sr;
    return out;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] exp_stream;
    logic [63:0] fin;
    logic [31:0] exp_upd;

    vecs[0] = '{"idcode_reload",  5'b00001, 32'h0,         32, 64'h0,  32, 64'h1000_0A4D, 1'b0};
    vecs[1] = '{"bypass_ones",    5'b11111, 32'h0,          8, 64'hA5,  1, 64'h0,         1'b0};
    vecs[2] = '{"user_full",      5'b10000, 32'hDEAD_BEEF, 32, 64'h1234_5678, 32,
                64'hDEAD_BEEF, 1'b1};
    vecs[3] = '{"unlisted_00110", 5'b00110, 32'h0,          8, 64'h3C,  1, 64'h0,         1'b0};
    vecs[4] = '{"idcode_overlong",5'b00001, 32'h0,         40, 64'hC3, 32, 64'h1000_0A4D, 1'b0};
    vecs[5] = '{"user_short",     5'b10000, 32'h0F0F_F0F0,  8, 64'h5A, 32, 64'h0F0F_F0F0, 1'b1};
    vecs[6] = '{"unlisted_00010", 5'b00010, 32'hFFFF_FFFF,  3, 64'h5,   1, 64'h0,         1'b0};

    set_tap(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    user_capture_data = '0;
    trst = 1'b1;
    #1 trst = 1'b0;
    #2;
    check("rst_instr",  64'(instr), 64'(OpIdcode));
    check("rst_tdo",    64'(tap.tdo), 64'd0);
    check("rst_tdo_oe", 64'(tap.tdo_oe), 64'd0);
    check("rst_upd",    64'(user_update_data), 64'd0);
    check("rst_pulse",  64'(user_update_pulse), 64'd0);
    @(posedge tck);
    #1 trst = 1'b1;
    exp_upd = '0;

    // IDCODE selected straight out of reset.
    oe_err = 0;
    shift_dr("idcode_after_rst", 32, 64'h0, 64'(IDCODE));
    check("idcode_after_rst_instr", 64'(instr), 64'(OpIdcode));
    check("idcode_after_rst_oe", 64'(oe_err), 64'd0);
    check("idcode_after_rst_upd", 64'(user_update_data), 64'(exp_upd));

    foreach (vecs[i]) begin
      user_capture_data = vecs[i].cap_data;
      oe_err = 0;
      load_ir(vecs[i].op);
      check({vecs[i].name, "_instr"}, 64'(instr), 64'(vecs[i].op));
      exp_stream = model_shift(vecs[i].exp_len, vecs[i].exp_cap, vecs[i].din, vecs[i].n, fin);
      shift_dr({vecs[i].name, "_dr"}, vecs[i].n, vecs[i].din, exp_stream);
      if (vecs[i].is_user) exp_upd = fin[31:0];
      check({vecs[i].name, "_oe"}, 64'(oe_err), 64'd0);
      check({vecs[i].name, "_upd"}, 64'(user_update_data), 64'(exp_upd));
      check({vecs[i].name, "_pulse"}, 64'(pulse_upd), 64'(vecs[i].is_user));
      check({vecs[i].name, "_pulse_next"}, 64'(pulse_next), 64'd0);
    end

    // Test-Logic-Reset via the TAP returns the instruction to IDCODE.
    load_ir(OpUser);
    check("tlr_pre_instr", 64'(instr), 64'(OpUser));
    for (int i = 0; i < 5; i++) begin
      set_tap(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
    end
    set_tap(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("tlr_instr", 64'(instr), 64'(OpIdcode));

    // trst in the middle of a USER shift.
    load_ir(OpUser);
    user_capture_data = 32'hCAFE_F00D;
    set_tap(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); cycle();
    for (int i = 0; i < 4; i++) begin
      set_tap(0, 0, 0, 0, 1, 0, 0, 0, 1, 1'b1); cycle();
    end
    check("trst_pre_oe", 64'(s_oe), 64'd1);
    check("trst_pre_tdo", 64'(s_tdo), 64'd1);  // bit 3 of 0xCAFEF00D
    check("trst_pre_instr", 64'(instr), 64'(OpUser));
    trst = 1'b0;
    #1;
    check("trst_instr", 64'(instr), 64'(OpIdcode));
    check("trst_tdo", 64'(tap.tdo), 64'd0);
    check("trst_tdo_oe", 64'(tap.tdo_oe), 64'd0);
    check("trst_upd", 64'(user_update_data), 64'd0);
    check("trst_pulse", 64'(user_update_pulse), 64'd0);
    set_tap(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge tck);
    #1 trst = 1'b1;
    cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
